hist_update_pipe: RTL and testbench
===================================

Name: hist_update_pipe

Overview:
- Write side of the histogram RAM: accepts a stream of bin indices and increments the count at each bin through a 3-stage read-modify-write pipeline.
- Same-bin back-to-back hits are forwarded, so every increment is counted.
- Owns the count storage.
- Exposes an independent read port (addr_r/ram_en/data_r) for the downstream histogram reader.
- Includes a clear sweeper FSM that zeroes all bins.

Parameters:
- ADDR_W, 5, bin index width.
- DEPTH, 32, number of bins (must be ≤ 2**ADDR_W).
- CNT_W, 16, count width per bin.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  bin sample valid
- in_bin  in  ADDR_W  bin index to increment
- in_ready  out  1  sample accepted when in_valid && in_ready
- clear_start  in  1  request full clear (pulse)
- clear_busy  out  1  high during DRAIN/CLEAR
- clear_done  out  1  one-cycle pulse when sweep finishes
- ram_en  in  1  external read request
- addr_r  in  ADDR_W  external read address
- data_r  out  CNT_W  read data, valid the cycle after ram_en
- rd_valid  out  1  registered ram_en

Behaviour:
- Storage: DEPTH x CNT_W register array. One internal write port, one pipeline read port, one external read port. Synchronous reads; a read colliding with a same-cycle write returns the old value.
- Pipeline stages:
  - S0 (cycle t): accept sample, register bin, issue internal read.
  - S1 (t+1): operand = forwarded or RAM data; compute operand+1.
  - S2 (t+2): write result.
- Increment visibility: an increment accepted at t is visible on the external read port for ram_en asserted at t+3 or later.
- Forwarding priority in S1 (newest first):
  1. S2 value if S2 valid and bins match.
  2. Value written in the previous cycle if bins match.
  3. RAM data.
- Throughput: one sample per cycle, no stalls in IDLE.
- in_bin >= DEPTH: sample accepted and dropped (no write).
- Arithmetic: CNT_W-bit, wraps modulo 2**CNT_W (see optional feature).
- FSM states: INIT, IDLE, DRAIN, CLEAR.
  - Reset → INIT. INIT behaves as CLEAR (sweep address 0..DEPTH-1, one bin per cycle, writing 0), then → IDLE. INIT does not pulse clear_done.
  - IDLE: in_ready=1. clear_start → DRAIN; a sample presented in the same cycle is not accepted (in_ready is already combinationally 0 when clear_start=1).
  - DRAIN: in_ready=0, wait 2 cycles until S1/S2 empty → CLEAR.
  - CLEAR: in_ready=0, write 0 to sweep address, increment address. After address DEPTH-1 is written → IDLE and pulse clear_done.
  - clear_start outside IDLE is ignored.
- clear_busy=1 in INIT, DRAIN, CLEAR.
- External reads are served in all states and never stall the pipeline. During a sweep they return 0 or the old value per the collision rule.
- Reset values: in_ready=0, clear_busy=1 (INIT), clear_done=0, rd_valid=0, data_r=0. Pipeline valids cleared, sweep address=0.
- Reset mid-operation: in-flight increments are discarded; the INIT sweep restarts from address 0.

Optional Feature:
- Macro HIST_SAT_EN.
  - Defined: increment saturates at 2**CNT_W-1; a saturated bin stays at all-ones, and forwarding carries the saturated value.
  - Undefined: increment wraps to 0.

Test Plan:
1. Reset then idle: rst high 2 cycles, release → clear_busy=1 for 32 cycles, in_ready=0, then in_ready=1; read all bins via ram_en → data_r=0 for each, rd_valid one cycle after ram_en.
2. Single hit: bin 1 at cycle t, ram_en addr_r=1 at t+3 → data_r=1 at t+4; ram_en at t+1 → data_r=0.
3. Back-to-back forwarding: bin 5 on 4 consecutive cycles, then bins 5,3,5 → bin 5 reads 6, bin 3 reads 1.
4. Clear while streaming: stream bin 2 continuously; pulse clear_start after 10 accepted samples → in_ready drops same cycle, DRAIN 2 cycles, CLEAR 32 cycles, clear_done pulse, all bins read 0, streaming resumes.
5. Overflow with CNT_W=4: 17 hits to bin 7 → reads 1 without HIST_SAT_EN, 15 with it.
6. Out-of-range and reset mid-stream: DEPTH=20, in_bin=25 → no bin changes; assert rst mid-stream → INIT sweep, all bins 0 afterward.

Source files
------------

// File: rtl/hist_update_pipe.sv
// Histogram write side: 3-stage read-modify-write increment pipeline with forwarding,
// a sweeper FSM that zeroes all bins, and an independent external read port.
// Define HIST_SAT_EN to make counts saturate at all-ones instead of wrapping.
module hist_update_pipe #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_bin,
  output logic              in_ready,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              ram_en,
  input  logic [ADDR_W-1:0] addr_r,
  output logic [CNT_W-1:0]  data_r,
  output logic              rd_valid
);
  typedef enum logic [1:0] {INIT, IDLE, DRAIN, CLEAR} state_e;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  logic [CNT_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              drain_q, drain_d;
  logic              clear_done_q, clear_done_d;
  logic [2:1]        vld_pipe_q, vld_pipe_d;
  logic [ADDR_W-1:0] s1_bin_q, s1_bin_d, s2_bin_q, s2_bin_d;
  logic [CNT_W-1:0]  s1_ram_q, s1_ram_d, s2_val_q, s2_val_d;
  logic              w_vld_q, w_vld_d;
  logic [ADDR_W-1:0] w_bin_q, w_bin_d;
  logic [CNT_W-1:0]  w_val_q, w_val_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]  data_r_q, data_r_d;

  logic              accept, in_range, rd_range, sweeping, we;
  logic [ADDR_W-1:0] wa;
  logic [CNT_W-1:0]  wd, operand, inc;

  assign sweeping   = (state_q == INIT) || (state_q == CLEAR);
  assign in_ready   = (state_q == IDLE) && !clear_start;
  assign accept     = in_valid && in_ready;
  assign in_range   = {1'b0, in_bin} < DEPTH_X;
  assign rd_range   = {1'b0, addr_r} < DEPTH_X;
  assign clear_busy = (state_q != IDLE);
  assign clear_done = clear_done_q;
  assign data_r     = data_r_q;
  assign rd_valid   = rd_valid_q;

  // Single write port: the sweeper owns it while sweeping, the pipeline's S2 otherwise.
  always_comb begin
    we = 1'b0;
    wa = s2_bin_q;
    wd = s2_val_q;
    if (sweeping) begin
      we = 1'b1;
      wa = sweep_q;
      wd = '0;
    end else if (vld_pipe_q[2]) begin
      we = 1'b1;
    end
  end

  // The S0 read misses both the S2 value in flight and the write landing on the
  // same edge as the read, so both are forwarded, newest first.
  always_comb begin
    operand = s1_ram_q;
    if (vld_pipe_q[2] && (s2_bin_q == s1_bin_q))  operand = s2_val_q;
    else if (w_vld_q && (w_bin_q == s1_bin_q))    operand = w_val_q;
  end

`ifdef HIST_SAT_EN
  assign inc = (&operand) ? operand : operand + CNT_W'(1);
`else
  assign inc = operand + CNT_W'(1);
`endif

  always_comb begin
    vld_pipe_d = {vld_pipe_q[1], accept && in_range};
    s1_bin_d   = in_bin;
    s1_ram_d   = in_range ? mem[in_bin] : '0;
    s2_bin_d   = s1_bin_q;
    s2_val_d   = inc;
    w_vld_d    = we;
    w_bin_d    = wa;
    w_val_d    = wd;
    rd_valid_d = ram_en;
    data_r_d   = data_r_q;
    if (ram_en) data_r_d = rd_range ? mem[addr_r] : '0;
  end

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    drain_d      = 1'b0;
    clear_done_d = 1'b0;
    case (state_q)
      INIT, CLEAR: begin
        sweep_d = sweep_q + ADDR_W'(1);
        if (sweep_q == LAST) begin
          state_d      = IDLE;
          sweep_d      = '0;
          clear_done_d = (state_q == CLEAR);
        end
      end
      IDLE:  if (clear_start) state_d = DRAIN;
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = CLEAR;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      drain_q      <= 1'b0;
      clear_done_q <= 1'b0;
      vld_pipe_q   <= '0;
      w_vld_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      data_r_q     <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      drain_q      <= drain_d;
      clear_done_q <= clear_done_d;
      vld_pipe_q   <= vld_pipe_d;
      w_vld_q      <= w_vld_d;
      rd_valid_q   <= rd_valid_d;
      data_r_q     <= data_r_d;
    end
    s1_bin_q <= s1_bin_d;
    s1_ram_q <= s1_ram_d;
    s2_bin_q <= s2_bin_d;
    s2_val_q <= s2_val_d;
    w_bin_q  <= w_bin_d;
    w_val_q  <= w_val_d;
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[wa] <= wd;
  end
endmodule

// File: tb/tb_hist_update_pipe.sv
// Bench for hist_update_pipe: a default instance checked against an array model of
// bin counts, plus a small instance (DEPTH=20, CNT_W=4) for overflow and out-of-range bins.
module tb_hist_update_pipe;
  localparam int DP = 32, SDP = 20;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid, in_ready, clear_start, clear_busy, clear_done, ram_en, rd_valid;
  logic [4:0]  in_bin, addr_r;
  logic [15:0] data_r;
  logic        s_in_valid, s_in_ready, s_clear_start, s_clear_busy, s_clear_done, s_ram_en, s_rd_valid;
  logic [4:0]  s_in_bin, s_addr_r;
  logic [3:0]  s_data_r;

  int total = 0, bad = 0;
  int unsigned model [DP];

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;

  always #5 clk = ~clk;

  hist_update_pipe #(.ADDR_W(5), .DEPTH(DP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bin(in_bin), .in_ready(in_ready),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .ram_en(ram_en), .addr_r(addr_r), .data_r(data_r), .rd_valid(rd_valid));

  hist_update_pipe #(.ADDR_W(5), .DEPTH(SDP), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_bin(s_in_bin), .in_ready(s_in_ready),
    .clear_start(s_clear_start), .clear_busy(s_clear_busy), .clear_done(s_clear_done),
    .ram_en(s_ram_en), .addr_r(s_addr_r), .data_r(s_data_r), .rd_valid(s_rd_valid));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int unsigned bump(input int unsigned v);
`ifdef HIST_SAT_EN
    return (v == 65535) ? v : v + 1;
`else
    return (v + 1) % 65536;
`endif
  endfunction

  task automatic clr_model();
    foreach (model[i]) model[i] = 0;
  endtask

  // Advance one cycle; the model counts whatever the handshake accepts on this edge.
  task automatic tick();
    @(negedge clk);
    if (in_valid && in_ready && int'(in_bin) < DP) model[in_bin] = bump(model[in_bin]);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic read_main(input string nm, input logic [4:0] a, input logic [31:0] exp);
    ram_en = 1'b1;
    addr_r = a;
    tick();
    chk({nm, " rd_valid"}, rd_valid, 1);
    chk(nm, data_r, exp);
    ram_en = 1'b0;
  endtask

  task automatic wait_ready(input string nm, input int exp_n);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk(nm, n, exp_n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [4:0] stab [11];
    rd_vec_t    rtab [5];
    int acc, n;
    logic [31:0] sexp, ovf;

    stab = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd3, 5'd5, 5'd9, 5'd9, 5'd3, 5'd9};
    rtab = '{'{5'd5, 16'd6}, '{5'd3, 16'd2}, '{5'd9, 16'd3}, '{5'd1, 16'd1}, '{5'd0, 16'd0}};
`ifdef HIST_SAT_EN
    ovf = 15;
`else
    ovf = 1;
`endif

    in_valid = 0; in_bin = 0; clear_start = 0; ram_en = 0; addr_r = 0;
    s_in_valid = 0; s_in_bin = 0; s_clear_start = 0; s_ram_en = 0; s_addr_r = 0;

    // Reset, INIT sweep, all bins zero
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clr_model();
    chk("reset in_ready", in_ready, 0);
    chk("reset clear_busy", clear_busy, 1);
    chk("reset clear_done", clear_done, 0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset data_r", data_r, 0);
    wait_ready("init sweep cycles", 32);
    chk("idle clear_busy", clear_busy, 0);
    chk("init no clear_done", clear_done, 0);
    for (int i = 0; i < DP; i++) read_main("init bin", 5'(i), 0);
    tick();
    chk("rd_valid drops", rd_valid, 0);

    // Single hit visibility: reads at t+1, t+2 see old value, t+3 sees the increment
    in_valid = 1'b1; in_bin = 5'd1;
    tick();
    in_valid = 1'b0; ram_en = 1'b1; addr_r = 5'd1;
    tick();
    chk("hit read t+1", data_r, 0);
    tick();
    chk("hit read t+2", data_r, 0);
    tick();
    chk("hit read t+3", data_r, 1);
    ram_en = 1'b0;

    // Back-to-back forwarding stream
    in_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_bin = stab[i];
      tick();
    end
    idle(3);
    for (int i = 0; i < 5; i++) read_main("fwd table", rtab[i].addr, 32'(rtab[i].exp));

    // Randomized stream with concurrent external reads
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_bin   = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      ram_en   = ($urandom_range(0, 1) == 1);
      addr_r   = 5'($urandom_range(0, 31));
      tick();
    end
    ram_en = 1'b0;
    idle(3);
    for (int i = 0; i < DP; i++) read_main("random bin", 5'(i), model[i]);

    // Clear while streaming bin 2
    in_valid = 1'b1; in_bin = 5'd2; acc = 0;
    while (acc < 10) begin
      if (in_ready) acc++;
      tick();
    end
    clear_start = 1'b1;
    #1;
    chk("in_ready on clear_start", in_ready, 0);
    tick();
    clear_start = 1'b0;
    n = 0;
    while (!clear_done && n < 200) begin
      clear_start = (n == 5);
      tick();
      n++;
    end
    clear_start = 1'b0;
    chk("drain+clear cycles", n, 34);
    chk("clear_busy after clear", clear_busy, 0);
    clr_model();
    tick();
    chk("clear_done one pulse", clear_done, 0);
    repeat (3) tick();
    idle(3);
    for (int i = 0; i < DP; i++) read_main("after clear bin", 5'(i), model[i]);
    read_main("resumed bin 2", 5'd2, 4);

    // Reset mid-stream restarts the sweep and discards in-flight increments
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_bin = 5'($urandom_range(0, 31));
      tick();
    end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    clr_model();
    wait_ready("reinit sweep cycles", 32);
    for (int i = 0; i < DP; i++) read_main("after reset bin", 5'(i), 0);

    // Small instance: overflow, out-of-range drop, last bin
    chk("small in_ready", s_in_ready, 1);
    s_in_valid = 1'b1; s_in_bin = 5'd7;
    repeat (17) tick();
    s_in_bin = 5'd25;
    repeat (3) tick();
    s_in_bin = 5'd19;
    tick();
    s_in_valid = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < SDP; i++) begin
      s_ram_en = 1'b1;
      s_addr_r = 5'(i);
      tick();
      sexp = (i == 7) ? ovf : (i == 19) ? 32'd1 : 32'd0;
      chk("small bin", s_data_r, sexp);
    end
    s_ram_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
